// File: rtl/nrzi_framer.sv
// nrzi_framer: hunts for a 16-bit sync word in a decoded NRZI bit stream, then
// assembles FRAME_BYTES bytes (LSB first) and reports frame boundaries.
// Optional build macro: NRZI_FRAMER_CRC_EN makes the final byte of each frame
// a CRC-8 (poly 0x07, init 0x00) checked against the preceding payload bits.
module nrzi_framer #(
   parameter logic [15:0] SYNC_WORD   = 16'hD391,
   parameter int unsigned FRAME_BYTES = 16
) (
   input  logic       refclk,
   input  logic       reset,
   input  logic       bit_stb,
   input  logic       bit_in,
   input  logic       loss,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_start,
   output logic       frame_end,
   output logic       frame_err,
   output logic       locked
);

   localparam int unsigned SHIFT_W    = 16;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned BIT_CNT_W  = 3;
   localparam int unsigned BYTE_CNT_W = 8;
   localparam logic [BYTE_CNT_W-1:0] LAST_IDX = BYTE_CNT_W'(FRAME_BYTES - 1);

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t                  state_q, state_d;
   logic                    stb_q;
   logic [SHIFT_W-1:0]      shift_q, shift_d;
   logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [BYTE_W-1:0]       byte_q, byte_d;
   logic [BYTE_W-1:0]       data_d;
   logic                    data_valid_d, frame_start_d, frame_end_d, frame_err_d, locked_d;
   logic                    accept_c;
   logic [SHIFT_W-1:0]      shift_next_c;
   logic [BYTE_W-1:0]       byte_next_c;
`ifdef NRZI_FRAMER_CRC_EN
   logic [BYTE_W-1:0]       crc_q, crc_d;
   logic [BYTE_W-1:0]       crc_step_c;
`endif

   // Bit acceptance on the rising edge of the strobe, plus candidate shift values
   always_comb begin
      accept_c     = bit_stb & ~stb_q;
      shift_next_c = {shift_q[SHIFT_W-2:0], bit_in};
      byte_next_c  = {bit_in, byte_q[BYTE_W-1:1]};
`ifdef NRZI_FRAMER_CRC_EN
      crc_step_c   = {crc_q[BYTE_W-2:0], 1'b0} ^ ((crc_q[BYTE_W-1] ^ bit_in) ? 8'h07 : 8'h00);
`endif
   end

   // Next-state and output decode; loss always takes priority over a bit
   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
      byte_cnt_d    = byte_cnt_q;
      byte_d        = byte_q;
      data_d        = data;
      data_valid_d  = 1'b0;
      frame_start_d = 1'b0;
      frame_end_d   = 1'b0;
      frame_err_d   = 1'b0;
`ifdef NRZI_FRAMER_CRC_EN
      crc_d         = crc_q;
`endif
      case (state_q)
         HUNT: begin
            if (loss) begin
               shift_d = '0;
            end else if (accept_c) begin
               shift_d = shift_next_c;
               if (shift_next_c == SYNC_WORD) begin
                  state_d       = LOCKED;
                  frame_start_d = 1'b1;
                  shift_d       = '0;
                  bit_cnt_d     = '0;
                  byte_cnt_d    = '0;
`ifdef NRZI_FRAMER_CRC_EN
                  crc_d         = '0;
`endif
               end
            end
         end
         LOCKED: begin
            if (loss) begin
               state_d     = HUNT;
               frame_err_d = 1'b1;
               shift_d     = '0;
               bit_cnt_d   = '0;
               byte_cnt_d  = '0;
            end else if (accept_c) begin
               byte_d    = byte_next_c;
               bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
`ifdef NRZI_FRAMER_CRC_EN
               if (byte_cnt_q != LAST_IDX) begin
                  crc_d = crc_step_c;
               end
`endif
               if (bit_cnt_q == BIT_CNT_W'(7)) begin
                  data_d       = byte_next_c;
                  data_valid_d = 1'b1;
                  byte_cnt_d   = byte_cnt_q + BYTE_CNT_W'(1);
                  if (byte_cnt_q == LAST_IDX) begin
                     state_d     = HUNT;
                     frame_end_d = 1'b1;
                     shift_d     = '0;
                     bit_cnt_d   = '0;
                     byte_cnt_d  = '0;
`ifdef NRZI_FRAMER_CRC_EN
                     frame_err_d = (byte_next_c != crc_q);
`endif
                  end
               end
            end
         end
         default: state_d = HUNT;
      endcase
      locked_d = (state_d == LOCKED);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge refclk) begin
      if (reset) begin
         state_q     <= HUNT;
         stb_q       <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         byte_q      <= '0;
         data        <= 8'h00;
         data_valid  <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         frame_err   <= 1'b0;
         locked      <= 1'b0;
`ifdef NRZI_FRAMER_CRC_EN
         crc_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         stb_q       <= bit_stb;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         byte_q      <= byte_d;
         data        <= data_d;
         data_valid  <= data_valid_d;
         frame_start <= frame_start_d;
         frame_end   <= frame_end_d;
         frame_err   <= frame_err_d;
         locked      <= locked_d;
`ifdef NRZI_FRAMER_CRC_EN
         crc_q       <= crc_d;
`endif
      end
   end

endmodule
